// File: rtl/sym_deframer.sv
// rtl/sym_deframer.sv - symbol stream deframer: sync hunt, length header, byte packing
module sym_deframer #(
  parameter int                    SYM_WIDTH  = 2,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 16'hD391
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [SYM_WIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [BYTE_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  locked,
  output logic                  sync_hit
);
  localparam int SPB = BYTE_WIDTH / SYM_WIDTH;
  localparam int CW  = (SPB > 1) ? $clog2(SPB) : 1;
  localparam logic [CW-1:0] LAST_SYM = CW'(SPB - 1);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

  state_t                state;
  logic [SYNC_WIDTH-1:0] sync_sr;
  logic [SYNC_WIDTH-1:0] sync_next;
  logic [BYTE_WIDTH-1:0] pack;
  logic [BYTE_WIDTH-1:0] pack_next;
  logic [BYTE_WIDTH-1:0] byte_cnt;
  logic [CW-1:0]         sym_cnt;
  logic                  sym_done;
  logic                  accept;

  // Only a byte-completing symbol needs a free output register; others always flow.
  always_comb begin
    sync_next = (sync_sr << SYM_WIDTH) | SYNC_WIDTH'(in_data);
    pack_next = (pack << SYM_WIDTH) | BYTE_WIDTH'(in_data);
    sym_done  = (sym_cnt == LAST_SYM);
    in_ready  = !(state == PAYLOAD && sym_done && out_valid && !out_ready);
    accept    = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      sync_sr   <= '0;
      pack      <= '0;
      sym_cnt   <= '0;
      byte_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      locked    <= 1'b0;
      sync_hit  <= 1'b0;
    end else begin
      sync_hit <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        case (state)
          HUNT: begin
            if (sync_next == SYNC_WORD) begin
              state    <= LEN;
              locked   <= 1'b1;
              sync_hit <= 1'b1;
              sync_sr  <= '0;
            end else begin
              sync_sr <= sync_next;
            end
          end
          LEN: begin
            if (sym_done) begin
              sym_cnt <= '0;
              pack    <= '0;
              if (pack_next == '0) begin
                state  <= HUNT;
                locked <= 1'b0;
              end else begin
                byte_cnt <= pack_next;
                state    <= PAYLOAD;
              end
            end else begin
              pack    <= pack_next;
              sym_cnt <= sym_cnt + CW'(1);
            end
          end
          PAYLOAD: begin
            if (sym_done) begin
              out_valid <= 1'b1;
              out_data  <= pack_next;
              out_last  <= (byte_cnt == BYTE_WIDTH'(1));
              byte_cnt  <= byte_cnt - BYTE_WIDTH'(1);
              pack      <= '0;
              sym_cnt   <= '0;
              // Hunting resumes while the final byte may still wait on out_ready.
              if (byte_cnt == BYTE_WIDTH'(1)) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end else begin
              pack    <= pack_next;
              sym_cnt <= sym_cnt + CW'(1);
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sym_deframer.sv
// tb/tb_sym_deframer.sv - scoreboard bench for sym_deframer
module tb_sym_deframer;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       locked;
  logic       sync_hit;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         rdy_mode = 0;
  bit         gap_mode = 0;
  int         byte_count = 0;
  int         sync_hits = 0;
  bit         stall_hold = 0;
  logic [7:0] hold_data;
  logic       hold_last;

  sym_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .locked    (locked),
    .sync_hit  (sync_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard pop on every output handshake, plus hold-stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_hold = 0;
    end else begin
      if (stall_hold) begin
        checks++;
        if (!out_valid || out_data !== hold_data || out_last !== hold_last) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%02h last=%0b, required valid=1 data=%02h last=%0b",
                   out_valid, out_data, out_last, hold_data, hold_last);
        end
      end
      if (out_valid && out_ready) begin
        logic [8:0] e;
        checks++;
        byte_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got data=%02h last=%0b, required no output", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL byte: got last=%0b data=%02h, required last=%0b data=%02h",
                     out_last, out_data, e[8], e[7:0]);
          end
        end
      end
      stall_hold = out_valid && !out_ready;
      hold_data  = out_data;
      hold_last  = out_last;
      if (sync_hit) sync_hits++;
    end
  end

  task automatic send_sym(input logic [1:0] s, output int stalls);
    bit ok;
    stalls = 0;
    if (gap_mode) begin
      while ($urandom_range(0, 15) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = s;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      stalls++;
      if (stalls > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", stalls);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int st;
    for (int i = 0; i < 4; i++) send_sym(b[7-2*i -: 2], st);
  endtask

  task automatic send_sync();
    send_byte(8'hD3);
    send_byte(8'h91);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic send_basic_frame();
    send_sync();
    send_byte(8'h02);
    exp_q.push_back({1'b0, 8'hA5});
    send_byte(8'hA5);
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
        locked !== 1'b0 || sync_hit !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%0b data=%02h last=%0b locked=%0b hit=%0b ready=%0b, required 0 00 0 0 0 1",
               out_valid, out_data, out_last, locked, sync_hit, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int h0 = sync_hits;
    int b0 = byte_count;
    rdy_mode = 0;
    send_sync();
    @(negedge clk);
    checks++;
    if (sync_hit !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL basic_sync_hit: hit=%0b locked=%0b, required 1 1", sync_hit, locked);
    end
    @(posedge clk);
    #1;
    send_byte(8'h02);
    exp_q.push_back({1'b0, 8'hA5});
    send_byte(8'hA5);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL basic_byte0: valid=%0b data=%02h last=%0b locked=%0b, required 1 a5 0 1",
               out_valid, out_data, out_last, locked);
    end
    @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_last !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL basic_byte1: valid=%0b data=%02h last=%0b locked=%0b, required 1 3c 1 0",
               out_valid, out_data, out_last, locked);
    end
    @(posedge clk);
    #1;
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || byte_count - b0 != 2 || sync_hits - h0 != 1) begin
      errors++;
      $display("FAIL basic_counts: pending=%0d bytes=%0d hits=%0d, required 0 2 1",
               exp_q.size(), byte_count - b0, sync_hits - h0);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0] junk[7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd0};
    int h0 = sync_hits;
    int b0 = byte_count;
    int st;
    foreach (junk[i]) send_sym(junk[i], st);
    @(negedge clk);
    checks++;
    if (sync_hits != h0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_junk: hits=%0d locked=%0b, required 0 0", sync_hits - h0, locked);
    end
    @(posedge clk);
    #1;
    send_basic_frame();
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || byte_count - b0 != 2 || sync_hits - h0 != 1) begin
      errors++;
      $display("FAIL misaligned_counts: pending=%0d bytes=%0d hits=%0d, required 0 2 1",
               exp_q.size(), byte_count - b0, sync_hits - h0);
    end
  endtask

  task automatic test_zero_length();
    int h0 = sync_hits;
    int b0 = byte_count;
    send_sync();
    send_byte(8'h00);
    @(negedge clk);
    checks++;
    if (locked !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_state: locked=%0b valid=%0b, required 0 0", locked, out_valid);
    end
    @(posedge clk);
    #1;
    send_sync();
    send_byte(8'h01);
    exp_q.push_back({1'b1, 8'h5A});
    send_byte(8'h5A);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || byte_count - b0 != 1 || sync_hits - h0 != 2) begin
      errors++;
      $display("FAIL zero_len_counts: pending=%0d bytes=%0d hits=%0d, required 0 1 2",
               exp_q.size(), byte_count - b0, sync_hits - h0);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [15:0] stall_mask = '0;
    int b0 = byte_count;
    rdy_mode = 2;
    send_sync();
    send_byte(8'h04);
    foreach (bytes[i]) exp_q.push_back({(i == 3), bytes[i]});
    fork
      begin
        int st;
        for (int i = 0; i < 16; i++) begin
          send_sym(bytes[i/4][7-2*(i%4) -: 2], st);
          stall_mask[i] = (st > 0);
        end
      end
      begin
        repeat (20) @(posedge clk);
        rdy_mode = 0;
      end
    join
    checks++;
    if (stall_mask !== 16'h0080) begin
      errors++;
      $display("FAIL bp_stall_mask: got %04h, required 0080", stall_mask);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || byte_count - b0 != 4) begin
      errors++;
      $display("FAIL bp_counts: pending=%0d bytes=%0d, required 0 4", exp_q.size(), byte_count - b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int h0;
    int b0;
    int st;
    rdy_mode = 2;
    send_sync();
    send_byte(8'h04);
    send_byte(8'h11);
    send_sym(2'd0, st);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: valid=%0b locked=%0b, required 0 0", out_valid, locked);
    end
    @(posedge clk);
    #1;
    h0 = sync_hits;
    b0 = byte_count;
    send_sym(2'd2, st);
    send_sym(2'd0, st);
    send_sym(2'd2, st);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sync_hits != h0 || byte_count != b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ignored: hits=%0d bytes=%0d locked=%0b, required 0 0 0",
               sync_hits - h0, byte_count - b0, locked);
    end
    send_sync();
    send_byte(8'h02);
    exp_q.push_back({1'b0, 8'hC3});
    send_byte(8'hC3);
    exp_q.push_back({1'b1, 8'h7E});
    send_byte(8'h7E);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || byte_count - b0 != 2 || sync_hits - h0 != 1) begin
      errors++;
      $display("FAIL rst_mid_recover: pending=%0d bytes=%0d hits=%0d, required 0 2 1",
               exp_q.size(), byte_count - b0, sync_hits - h0);
    end
  endtask

  task automatic test_random();
    int h0 = sync_hits;
    int b0 = byte_count;
    int total = 0;
    int len;
    logic [7:0] b;
    gap_mode = 1;
    rdy_mode = 1;
    for (int f = 0; f < 100; f++) begin
      len = (f == 0) ? 1 : (f == 1) ? 255 : $urandom_range(1, 255);
      send_sync();
      send_byte(8'(len));
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        exp_q.push_back({(k == len - 1), b});
        send_byte(b);
      end
      total += len;
    end
    wait_drain();
    gap_mode = 0;
    rdy_mode = 0;
    checks++;
    if (exp_q.size() != 0 || byte_count - b0 != total || sync_hits - h0 != 100) begin
      errors++;
      $display("FAIL random_counts: pending=%0d bytes=%0d hits=%0d, required 0 %0d 100",
               exp_q.size(), byte_count - b0, sync_hits - h0, total);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 2'd0;
    test_reset();
    test_basic();
    test_misaligned();
    test_zero_length();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sym_deframer.md
Name: sym_deframer

Overview:
- Receive-side counterpart of the transmit byte-to-symbol path.
- Accepts a valid/ready stream of narrow symbols, for example the 2-bit QPSK symbols produced by the TX resizer.
- Hunts for a sync word at arbitrary symbol alignment, reads a one-byte length header, then packs the following payload symbols into bytes on a valid/ready output, flagging the last byte of each frame.
- Sits between the demodulator symbol output and the byte-level packet sink.

Parameters:
- SYM_WIDTH, 2, bits per input symbol; must divide BYTE_WIDTH and SYNC_WIDTH.
- BYTE_WIDTH, 8, output byte width, also the width of the length header.
- SYNC_WIDTH, 16, sync word length in bits.
- SYNC_WORD, 16'hD391, sync pattern, transmitted MSB first.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  input symbol valid.
- in_data  in  SYM_WIDTH  input symbol; MSB is the earlier bit.
- in_ready  out  1  block can accept a symbol.
- out_valid  out  1  output byte valid.
- out_data  out  BYTE_WIDTH  payload byte, first-received bit in the MSB.
- out_last  out  1  qualifies out_data as the final byte of a frame.
- out_ready  in  1  downstream accepts the byte.
- locked  out  1  high in the LEN and PAYLOAD states.
- sync_hit  out  1  one-cycle pulse on sync detection.

Behaviour:
- Handshake: a symbol transfers when in_valid && in_ready; a byte transfers when out_valid && out_ready.
- Reset, applied on the clk edge with rst high:
  - state = HUNT.
  - sync shift register, pack register, symbol counter and byte counter cleared.
  - out_valid = 0, out_data = 0, out_last = 0, locked = 0, sync_hit = 0.
- Reset mid-frame: the partial byte and the remaining frame are discarded. A pending out_valid is dropped without handshake.
- HUNT state:
  - in_ready = 1.
  - Each accepted symbol shifts into the LSBs of a SYNC_WIDTH-bit register; older bits move toward the MSB.
  - A match is evaluated on the post-shift value and is checked on every symbol, so any symbol alignment is found.
  - On a match: the next state is LEN, sync_hit pulses for that one clock edge, and the shift register clears.
  - The next accepted symbol is the first length symbol.
- LEN state:
  - in_ready = 1.
  - Packs BYTE_WIDTH/SYM_WIDTH symbols, MSB first, into the length value N.
  - N == 0: return to HUNT; no output is produced.
  - N > 0: load the byte counter with N and go to PAYLOAD.
- PAYLOAD state:
  - Packs symbols MSB first into a byte.
  - When a byte completes, it loads the output register on the same edge: out_valid = 1, out_data = byte, out_last = (byte counter == 1).
  - Latency: out_valid rises one cycle after the final symbol of the byte is accepted.
  - in_ready = 1, except when the next symbol would complete a byte while out_valid && !out_ready. In that case in_ready = 0.
  - A completing symbol is allowed on the same cycle as an output handshake, giving full throughput with no bubble.
  - Non-completing symbols are never stalled by the output.
  - After the byte with out_last is loaded, the state returns to HUNT. Sync hunting for the next frame proceeds while that byte waits on out_ready.
- Output register:
  - out_valid stays high and out_data/out_last stay stable until the handshake.
  - out_valid clears on a handshake unless a new byte loads on the same edge.
- Symbols presented without in_valid are ignored in all states; counters advance only on accepted symbols.
- Payload bytes are never inspected for sync. A sync pattern inside the payload does not restart the frame.

Test Plan:
- Basic frame:
  - Stimulus: SYM_WIDTH=2, out_ready=1. Symbols 3,1,0,3,2,1,0,1 (0xD391), then length 0,0,0,2 (0x02), then 2,2,1,1 (0xA5) and 0,3,3,0 (0x3C).
  - Required: sync_hit one cycle after the 8th symbol. Bytes 0xA5 (last=0) then 0x3C (last=1). locked falls after 0x3C loads.
- Misaligned hunt:
  - Stimulus: junk symbols 1,2 before the same frame, plus a partial sync 3,1,0,3,0.
  - Required: no sync_hit on the junk or partial sync; an identical output to the basic frame.
- Zero length:
  - Stimulus: sync, then length 0x00, then an immediate second sync with length 0x01 and payload 0x5A.
  - Required: no output for the first frame; a single byte 0x5A with last=1.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles during a 4-byte payload.
  - Required: in_ready drops only on the symbol that would complete byte 2. Bytes are delivered in order once out_ready=1, with no loss or duplication and stable data while stalled.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle after 5 payload symbols.
  - Required: out_valid=0 and locked=0 the next cycle. Remaining payload symbols are ignored until a fresh sync, and the following frame decodes correctly.
- Random traffic:
  - Stimulus: random in_valid/out_ready with 100 random frames of length 1..255.
  - Required: the scoreboard matches every byte and every out_last.
